vec_cache_wr_req_bank_xbar: RTL and testbench

// - Parametrised N-to-M write-request crossbar between the west write-command ports and the per-bank write pipelines.
// - Decodes the target bank from a configurable address bit field.
// - Runs an independent round-robin arbiter per bank.
// - Binds each accepted request to a write-data-buffer entry from that bank's allocator.
// - Holds each result in a one-deep registered output slot per bank; full throughput, one cycle of latency.

---
 rtl/vec_cache_wr_req_bank_xbar_if.sv | 35 +++
 rtl/vec_cache_wr_req_bank_xbar.sv | 83 ++++++++
 tb/tb_vec_cache_wr_req_bank_xbar.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/vec_cache_wr_req_bank_xbar_if.sv
// Request, allocator and bank-slot bundle of the write-request bank crossbar.
// The crossbar connects through the slave modport; traffic sources and bank pipelines use master.
interface vec_cache_wr_req_bank_xbar_if #(
    parameter int N_IN         = 8,
    parameter int M_BANK       = 4,
    parameter int ADDR_WIDTH   = 64,
    parameter int PLD_WIDTH    = 640,
    parameter int DB_IDX_WIDTH = 6
) ();
    localparam int SRC_WIDTH = $clog2(N_IN);

    logic [N_IN-1:0]                      in_vld;
    logic [N_IN-1:0][ADDR_WIDTH-1:0]      in_addr;
    logic [N_IN-1:0][PLD_WIDTH-1:0]       in_pld;
    logic [N_IN-1:0]                      in_rdy;
    logic [M_BANK-1:0]                    alloc_vld;
    logic [M_BANK-1:0][DB_IDX_WIDTH-1:0]  alloc_idx;
    logic [M_BANK-1:0]                    alloc_rdy;
    logic [M_BANK-1:0]                    out_vld;
    logic [M_BANK-1:0][ADDR_WIDTH-1:0]    out_addr;
    logic [M_BANK-1:0][PLD_WIDTH-1:0]     out_pld;
    logic [M_BANK-1:0][DB_IDX_WIDTH-1:0]  out_db_idx;
    logic [M_BANK-1:0][SRC_WIDTH-1:0]     out_src;
    logic [M_BANK-1:0]                    out_rdy;

    modport slave (
        input  in_vld, in_addr, in_pld, alloc_vld, alloc_idx, out_rdy,
        output in_rdy, alloc_rdy, out_vld, out_addr, out_pld, out_db_idx, out_src
    );

    modport master (
        output in_vld, in_addr, in_pld, alloc_vld, alloc_idx, out_rdy,
        input  in_rdy, alloc_rdy, out_vld, out_addr, out_pld, out_db_idx, out_src
    );
endinterface

// File: rtl/vec_cache_wr_req_bank_xbar.sv
// N-to-M write-request crossbar: bank decode from an address field, round-robin arbitration per bank,
// data-buffer entry binding and a one-deep registered output slot per bank.
module vec_cache_wr_req_bank_xbar #(
    parameter int N_IN         = 8,
    parameter int M_BANK       = 4,
    parameter int ADDR_WIDTH   = 64,
    parameter int SEL_LSB      = 62,
    parameter int PLD_WIDTH    = 640,
    parameter int DB_IDX_WIDTH = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    vec_cache_wr_req_bank_xbar_if.slave   bus
);
    localparam int SEL_WIDTH = $clog2(M_BANK);
    localparam int SRC_WIDTH = $clog2(N_IN);

    logic [M_BANK-1:0][N_IN-1:0]      req;
    logic [M_BANK-1:0][SRC_WIDTH-1:0] ptr;
    logic [M_BANK-1:0][SRC_WIDTH-1:0] win;
    logic [M_BANK-1:0]                free;
    logic [M_BANK-1:0]                accept;

    function automatic logic [SRC_WIDTH-1:0] rr_idx(input logic [SRC_WIDTH-1:0] base, input int k);
        return SRC_WIDTH'((int'(base) + k) % N_IN);
    endfunction

    // Scanning offsets from high to low lets the nearest requester at or after ptr win.
    always_comb begin
        req    = '0;
        win    = '0;
        free   = '0;
        accept = '0;
        for (int b = 0; b < M_BANK; b++) begin
            for (int i = 0; i < N_IN; i++) begin
                req[b][i] = bus.in_vld[i] &&
                            (bus.in_addr[i][SEL_LSB +: SEL_WIDTH] == SEL_WIDTH'(b));
            end
            for (int k = N_IN - 1; k >= 0; k--) begin
                if (req[b][rr_idx(ptr[b], k)]) begin
                    win[b] = rr_idx(ptr[b], k);
                end
            end
            free[b]   = !bus.out_vld[b] || bus.out_rdy[b];
            accept[b] = free[b] && bus.alloc_vld[b] && (|req[b]);
        end
    end

    always_comb begin
        bus.in_rdy    = '0;
        bus.alloc_rdy = accept;
        for (int b = 0; b < M_BANK; b++) begin
            if (accept[b]) begin
                bus.in_rdy[win[b]] = 1'b1;
            end
        end
    end

    // A draining slot with nothing to refill only drops valid; its data fields keep stale contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_vld    <= '0;
            bus.out_addr   <= '0;
            bus.out_pld    <= '0;
            bus.out_db_idx <= '0;
            bus.out_src    <= '0;
            ptr            <= '0;
        end else begin
            for (int b = 0; b < M_BANK; b++) begin
                if (accept[b]) begin
                    bus.out_vld[b]    <= 1'b1;
                    bus.out_addr[b]   <= bus.in_addr[win[b]];
                    bus.out_pld[b]    <= bus.in_pld[win[b]];
                    bus.out_db_idx[b] <= bus.alloc_idx[b];
                    bus.out_src[b]    <= win[b];
                    ptr[b]            <= rr_idx(win[b], 1);
                end else if (bus.out_rdy[b]) begin
                    bus.out_vld[b] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_vec_cache_wr_req_bank_xbar.sv
// Directed bench for the write-request bank crossbar: default 8x4 instance plus a 16x8 instance.
module tb_vec_cache_wr_req_bank_xbar;
    localparam int N_IN = 8, M_BANK = 4, ADDR_WIDTH = 64, SEL_LSB = 62, PLD_WIDTH = 640, DB_IDX_WIDTH = 6;

    logic clk = 1'b0;
    logic rst_n;
    int   testCount = 0;
    int   failCount = 0;
    int   seq [6] = '{1, 4, 6, 1, 4, 6};

    always #5 clk = ~clk;

    vec_cache_wr_req_bank_xbar_if #(.N_IN(N_IN), .M_BANK(M_BANK), .ADDR_WIDTH(ADDR_WIDTH),
        .PLD_WIDTH(PLD_WIDTH), .DB_IDX_WIDTH(DB_IDX_WIDTH)) bus ();
    vec_cache_wr_req_bank_xbar_if #(.N_IN(16), .M_BANK(8), .ADDR_WIDTH(16),
        .PLD_WIDTH(8), .DB_IDX_WIDTH(4)) bus2 ();

    vec_cache_wr_req_bank_xbar #(.N_IN(N_IN), .M_BANK(M_BANK), .ADDR_WIDTH(ADDR_WIDTH),
        .SEL_LSB(SEL_LSB), .PLD_WIDTH(PLD_WIDTH), .DB_IDX_WIDTH(DB_IDX_WIDTH))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    vec_cache_wr_req_bank_xbar #(.N_IN(16), .M_BANK(8), .ADDR_WIDTH(16),
        .SEL_LSB(6), .PLD_WIDTH(8), .DB_IDX_WIDTH(4))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    function automatic logic [63:0] addrFor(input int bank, input int tag);
        return {2'(bank), 62'(tag)};
    endfunction

    function automatic logic [639:0] pldFor(input int tag);
        logic [31:0] t;
        t = 32'(tag) ^ 32'hA5A5_0000;
        return {20{t}};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.in_vld     = '0;
        bus.in_addr    = '0;
        bus.in_pld     = '0;
        bus.alloc_vld  = '0;
        bus.alloc_idx  = '0;
        bus.out_rdy    = '1;
        bus2.in_vld    = '0;
        bus2.in_addr   = '0;
        bus2.in_pld    = '0;
        bus2.alloc_vld = '0;
        bus2.alloc_idx = '0;
        bus2.out_rdy   = '1;

        #3;
        checkOutput("reset_out_vld", 64'(bus.out_vld), 64'h0);
        checkOutput("reset_in_rdy", 64'(bus.in_rdy), 64'h0);
        checkOutput("reset_alloc_rdy", 64'(bus.alloc_rdy), 64'h0);
        checkOutput("reset_out_src", 64'(bus.out_src), 64'h0);
        checkOutput("reset_out_db_idx", 64'(bus.out_db_idx), 64'h0);
        step;
        step;
        rst_n = 1'b1;

        // single request: in0 -> bank 2, entry 5
        bus.in_addr[0]   = addrFor(2, 'h100);
        bus.in_pld[0]    = pldFor('h100);
        bus.in_vld       = 8'h01;
        bus.alloc_vld    = 4'b0100;
        bus.alloc_idx[2] = 6'd5;
        #1;
        checkOutput("single_in_rdy", 64'(bus.in_rdy), 64'h01);
        checkOutput("single_alloc_rdy", 64'(bus.alloc_rdy), 64'h4);
        step;
        bus.in_vld    = '0;
        bus.alloc_vld = '0;
        checkOutput("single_out_vld", 64'(bus.out_vld), 64'h4);
        checkOutput("single_db_idx", 64'(bus.out_db_idx[2]), 64'd5);
        checkOutput("single_src", 64'(bus.out_src[2]), 64'd0);
        checkOutput("single_addr", bus.out_addr[2], addrFor(2, 'h100));
        checkOutput("single_pld", bus.out_pld[2][63:0], pldFor('h100) & 640'hFFFF_FFFF_FFFF_FFFF);
        step;
        checkOutput("single_drain", 64'(bus.out_vld), 64'h0);

        // contention on bank 0 from in1, in4, in6
        bus.alloc_vld = 4'hF;
        bus.alloc_idx = '0;
        bus.in_addr[1] = addrFor(0, 1);
        bus.in_addr[4] = addrFor(0, 4);
        bus.in_addr[6] = addrFor(0, 6);
        bus.in_vld     = 8'b0101_0010;
        for (int j = 0; j < 6; j++) begin
            #1;
            checkOutput("contend_in_rdy", 64'(bus.in_rdy), 64'(1) << seq[j]);
            checkOutput("contend_alloc_rdy", 64'(bus.alloc_rdy), 64'h1);
            step;
            checkOutput("contend_src", 64'(bus.out_src[0]), 64'(seq[j]));
            checkOutput("contend_vld", 64'(bus.out_vld[0]), 64'h1);
        end
        bus.in_vld = '0;
        step;

        // no allocation for bank 3
        bus.alloc_vld    = 4'b0111;
        bus.in_addr[2]   = addrFor(3, 'h200);
        bus.in_vld       = 8'h04;
        for (int j = 0; j < 20; j++) begin
            #1;
            checkOutput("noalloc_rdys", 64'({bus.in_rdy, bus.alloc_rdy}), 64'h0);
            step;
        end
        bus.alloc_vld    = 4'hF;
        bus.alloc_idx[3] = 6'd9;
        #1;
        checkOutput("noalloc_in_rdy", 64'(bus.in_rdy), 64'h04);
        checkOutput("noalloc_alloc_rdy", 64'(bus.alloc_rdy), 64'h8);
        step;
        bus.in_vld = '0;
        checkOutput("noalloc_out_vld", 64'(bus.out_vld[3]), 64'h1);
        checkOutput("noalloc_db_idx", 64'(bus.out_db_idx[3]), 64'd9);
        checkOutput("noalloc_src", 64'(bus.out_src[3]), 64'd2);

        // backpressure on bank 1
        bus.out_rdy      = 4'b1101;
        bus.in_addr[3]   = addrFor(1, 'h300);
        bus.alloc_idx[1] = 6'd11;
        bus.in_vld       = 8'h08;
        #1;
        checkOutput("bp_first_in_rdy", 64'(bus.in_rdy), 64'h08);
        step;
        bus.in_addr[3]   = addrFor(1, 'h301);
        bus.alloc_idx[1] = 6'd12;
        checkOutput("bp_out_vld", 64'(bus.out_vld[1]), 64'h1);
        checkOutput("bp_src", 64'(bus.out_src[1]), 64'd3);
        for (int j = 0; j < 3; j++) begin
            #1;
            checkOutput("bp_hold_rdys", 64'({bus.in_rdy, bus.alloc_rdy}), 64'h0);
            step;
            checkOutput("bp_hold_addr", bus.out_addr[1], addrFor(1, 'h300));
            checkOutput("bp_hold_db_idx", 64'(bus.out_db_idx[1]), 64'd11);
            checkOutput("bp_hold_vld", 64'(bus.out_vld[1]), 64'h1);
        end
        bus.out_rdy = 4'hF;
        #1;
        checkOutput("bp_refill_in_rdy", 64'(bus.in_rdy), 64'h08);
        checkOutput("bp_refill_alloc_rdy", 64'(bus.alloc_rdy), 64'h2);
        step;
        bus.in_vld = '0;
        checkOutput("bp_refill_vld", 64'(bus.out_vld[1]), 64'h1);
        checkOutput("bp_refill_addr", bus.out_addr[1], addrFor(1, 'h301));
        checkOutput("bp_refill_db_idx", 64'(bus.out_db_idx[1]), 64'd12);

        // parallel banks: in0..in3 -> banks 0..3
        for (int b = 0; b < 4; b++) begin
            bus.in_addr[b]   = addrFor(b, 'h400 + b);
            bus.alloc_idx[b] = 6'(20 + b);
        end
        bus.alloc_vld = 4'hF;
        bus.in_vld    = 8'h0F;
        #1;
        checkOutput("par_in_rdy", 64'(bus.in_rdy), 64'h0F);
        checkOutput("par_alloc_rdy", 64'(bus.alloc_rdy), 64'hF);
        step;
        bus.in_vld  = '0;
        bus.out_rdy = 4'h0;
        checkOutput("par_out_vld", 64'(bus.out_vld), 64'hF);
        checkOutput("par_out_src", 64'(bus.out_src), 64'({3'd3, 3'd2, 3'd1, 3'd0}));
        checkOutput("par_db_idx", 64'(bus.out_db_idx), 64'({6'd23, 6'd22, 6'd21, 6'd20}));
        step;
        checkOutput("par_held_vld", 64'(bus.out_vld), 64'hF);

        // reset mid-stream with all slots full
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_vld", 64'(bus.out_vld), 64'h0);
        checkOutput("midrst_out_src", 64'(bus.out_src), 64'h0);
        #2;
        rst_n          = 1'b1;
        bus.out_rdy    = 4'hF;
        bus.in_addr[0] = addrFor(0, 'h500);
        bus.in_addr[5] = addrFor(0, 'h505);
        bus.in_vld     = 8'h21;
        #1;
        checkOutput("postrst_in_rdy", 64'(bus.in_rdy), 64'h01);
        step;
        checkOutput("postrst_src", 64'(bus.out_src[0]), 64'd0);
        #1;
        checkOutput("postrst_next_in_rdy", 64'(bus.in_rdy), 64'h20);
        step;
        checkOutput("postrst_next_src", 64'(bus.out_src[0]), 64'd5);
        bus.in_vld = '0;

        // 16x8 instance, bank field at addr[8:6]
        for (int b = 0; b < 8; b++) begin
            bus2.in_addr[8 + b] = 16'(b << 6);
            bus2.in_pld[8 + b]  = 8'(b);
            bus2.alloc_idx[b]   = 4'(b);
        end
        bus2.alloc_vld = 8'hFF;
        bus2.in_vld    = 16'hFF00;
        #1;
        checkOutput("wide_in_rdy", 64'(bus2.in_rdy), 64'hFF00);
        checkOutput("wide_alloc_rdy", 64'(bus2.alloc_rdy), 64'hFF);
        step;
        bus2.in_vld = '0;
        checkOutput("wide_out_vld", 64'(bus2.out_vld), 64'hFF);
        checkOutput("wide_src7", 64'(bus2.out_src[7]), 64'd15);
        checkOutput("wide_src0", 64'(bus2.out_src[0]), 64'd8);
        checkOutput("wide_db_idx5", 64'(bus2.out_db_idx[5]), 64'd5);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
